// File: rtl/bcd_down_timer_pkg.sv
// rtl/bcd_down_timer_pkg.sv - shared state encoding and BCD limits for bcd_down_timer
package bcd_down_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] DIGIT_MAX    = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;

   function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD down-counting digit with wrap to MAX and borrow out
module bcd_down_digit
   import bcd_down_timer_pkg::*;
#(
   parameter logic [3:0] MAX = DIGIT_MAX
) (
   input  logic       CP,
   input  logic       nCLR,
   input  logic       load,
   input  logic [3:0] ld_val,
   input  logic       dec,
   output logic [3:0] Q,
   output logic       borrow
);

   always_ff @(posedge CP or negedge nCLR) begin
      if (!nCLR) begin
         Q <= 4'd0;
      end else if (load) begin
         Q <= ld_val;
      end else if (dec) begin
         Q <= (Q == 4'd0) ? MAX : Q - 4'd1;
      end
   end

   assign borrow = dec & (Q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - MM:SS BCD countdown timer with expiry pulse and timed alarm
// Optional TIMER_AUTO_RELOAD_EN: reload from the last loaded value at expiry and keep running.
module bcd_down_timer
   import bcd_down_timer_pkg::*;
#(
   parameter int MIN_TENS_MAX = 5,
   parameter int ALARM_TICKS  = 8
) (
   input  logic       CP,
   input  logic       nCLR,
   input  logic       TICK,
   input  logic       LOAD,
   input  logic [3:0] LD_M1,
   input  logic [3:0] LD_M0,
   input  logic [3:0] LD_S1,
   input  logic [3:0] LD_S0,
   input  logic       START,
   input  logic       PAUSE,
   output logic [3:0] M1,
   output logic [3:0] M0,
   output logic [3:0] S1,
   output logic [3:0] S0,
   output logic       RUNNING,
   output logic       EXPIRED,
   output logic       ALARM
);

   localparam logic [3:0] M1_MAX = 4'(MIN_TENS_MAX);
   localparam int         CW     = $clog2(ALARM_TICKS + 1);

   state_t          state_q, state_d;
   logic            running_q, expired_q, alarm_q;
   logic            expired_d, alarm_d;
   logic [CW-1:0]   acnt_q, acnt_d;
   logic            tick_dec, reload;
   logic            cnt_zero, cnt_one;
   logic            dig_load;
   logic [15:0]     clamped, ld_word;
   logic            b_s0, b_s1, b_m0, b_m1;

   assign clamped = {clamp_digit(LD_M1, M1_MAX), clamp_digit(LD_M0, DIGIT_MAX),
                     clamp_digit(LD_S1, SEC_TENS_MAX), clamp_digit(LD_S0, DIGIT_MAX)};

   assign cnt_zero = ({M1, M0, S1, S0} == 16'h0000);
   assign cnt_one  = ({M1, M0, S1, S0} == 16'h0001);

`ifdef TIMER_AUTO_RELOAD_EN
   logic [15:0] shadow_q;
   logic        shadow_zero;

   always_ff @(posedge CP or negedge nCLR) begin
      if (!nCLR) begin
         shadow_q <= 16'h0000;
      end else if (LOAD) begin
         shadow_q <= clamped;
      end
   end

   assign shadow_zero = (shadow_q == 16'h0000);
   assign ld_word     = LOAD ? clamped : shadow_q;
`else
   assign ld_word     = clamped;
`endif

   always_ff @(posedge CP or negedge nCLR) begin
      if (!nCLR) begin
         state_q   <= ST_IDLE;
         running_q <= 1'b0;
         expired_q <= 1'b0;
         alarm_q   <= 1'b0;
         acnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         running_q <= (state_d == ST_RUN);
         expired_q <= expired_d;
         alarm_q   <= alarm_d;
         acnt_q    <= acnt_d;
      end
   end

   // Each request is only considered when every higher-priority one is idle.
   always_comb begin
      state_d   = state_q;
      alarm_d   = alarm_q;
      acnt_d    = acnt_q;
      expired_d = 1'b0;
      tick_dec  = 1'b0;
      reload    = 1'b0;
      if (LOAD) begin
         state_d = ST_IDLE;
         alarm_d = 1'b0;
         acnt_d  = '0;
      end else if (PAUSE) begin
         if (state_q == ST_RUN) state_d = ST_PAUSE;
      end else if (START && state_q != ST_RUN) begin
         case (state_q)
            ST_IDLE:  if (!cnt_zero) state_d = ST_RUN;
            ST_PAUSE: state_d = ST_RUN;
            ST_DONE: begin
               state_d = ST_IDLE;
               alarm_d = 1'b0;
               acnt_d  = '0;
            end
            default: state_d = state_q;
         endcase
      end else if (TICK) begin
         case (state_q)
            ST_RUN: begin
               if (cnt_one) begin
                  expired_d = 1'b1;
                  alarm_d   = 1'b1;
                  acnt_d    = '0;
`ifdef TIMER_AUTO_RELOAD_EN
                  if (!shadow_zero) begin
                     reload = 1'b1;
                  end else begin
                     tick_dec = 1'b1;
                     state_d  = ST_DONE;
                  end
`else
                  tick_dec = 1'b1;
                  state_d  = ST_DONE;
`endif
               end else begin
                  tick_dec = 1'b1;
                  // Alarm window keeps timing while a reloaded count runs on.
                  if (alarm_q) begin
                     acnt_d = acnt_q + 1'b1;
                     if (acnt_d == CW'(ALARM_TICKS)) alarm_d = 1'b0;
                  end
               end
            end
            ST_DONE: begin
               acnt_d = acnt_q + 1'b1;
               if (acnt_d == CW'(ALARM_TICKS)) begin
                  alarm_d = 1'b0;
                  state_d = ST_IDLE;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   assign dig_load = LOAD | reload;

   bcd_down_digit #(.MAX(DIGIT_MAX)) u_s0 (
      .CP(CP), .nCLR(nCLR), .load(dig_load), .ld_val(ld_word[3:0]),
      .dec(tick_dec), .Q(S0), .borrow(b_s0)
   );

   bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_s1 (
      .CP(CP), .nCLR(nCLR), .load(dig_load), .ld_val(ld_word[7:4]),
      .dec(b_s0), .Q(S1), .borrow(b_s1)
   );

   bcd_down_digit #(.MAX(DIGIT_MAX)) u_m0 (
      .CP(CP), .nCLR(nCLR), .load(dig_load), .ld_val(ld_word[11:8]),
      .dec(b_s1), .Q(M0), .borrow(b_m0)
   );

   // M1 never underflows since RUN is never entered at 00:00.
   bcd_down_digit #(.MAX(M1_MAX)) u_m1 (
      .CP(CP), .nCLR(nCLR), .load(dig_load), .ld_val(ld_word[15:12]),
      .dec(b_m0), .Q(M1), .borrow(b_m1)
   );

   assign RUNNING = running_q;
   assign EXPIRED = expired_q;
   assign ALARM   = alarm_q;

   logic unused_borrow;
   assign unused_borrow = b_m1;

endmodule

// File: tb/tb_bcd_down_timer.sv
// tb/tb_bcd_down_timer.sv - self-checking bench for bcd_down_timer against a seconds-based model
module tb_bcd_down_timer;

   localparam int ALARM_TICKS = 8;

   logic       CP, nCLR, TICK, LOAD, START, PAUSE;
   logic [3:0] LD_M1, LD_M0, LD_S1, LD_S0;
   logic [3:0] M1, M0, S1, S0;
   logic       RUNNING, EXPIRED, ALARM;

   bcd_down_timer #(.MIN_TENS_MAX(5), .ALARM_TICKS(ALARM_TICKS)) dut (
      .CP(CP), .nCLR(nCLR), .TICK(TICK), .LOAD(LOAD),
      .LD_M1(LD_M1), .LD_M0(LD_M0), .LD_S1(LD_S1), .LD_S0(LD_S0),
      .START(START), .PAUSE(PAUSE),
      .M1(M1), .M0(M0), .S1(S1), .S0(S0),
      .RUNNING(RUNNING), .EXPIRED(EXPIRED), .ALARM(ALARM)
   );

   initial CP = 1'b0;
   always #5 CP = ~CP;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // Model: count as total seconds, mode 0 idle / 1 run / 2 pause / 3 done.
   int m_secs, m_shadow, m_mode, m_acnt;
   bit m_exp, m_alarm;

   function automatic logic [15:0] to_bcd(input int secs);
      int mm, ss;
      mm = secs / 60;
      ss = secs % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic int lim(input logic [3:0] v, input int mx);
      return (int'(v) > mx) ? mx : int'(v);
   endfunction

   task automatic model_reset();
      m_secs = 0; m_shadow = 0; m_mode = 0; m_acnt = 0; m_exp = 0; m_alarm = 0;
   endtask

   task automatic model_step();
      bit reload_on;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_on = 1'b1;
`else
      reload_on = 1'b0;
`endif
      m_exp = 1'b0;
      if (LOAD) begin
         m_secs = lim(LD_M1, 5) * 600 + lim(LD_M0, 9) * 60 + lim(LD_S1, 5) * 10 + lim(LD_S0, 9);
         m_shadow = m_secs;
         m_mode = 0; m_alarm = 0; m_acnt = 0;
      end else if (PAUSE) begin
         if (m_mode == 1) m_mode = 2;
      end else if (START && m_mode != 1) begin
         if (m_mode == 0 && m_secs != 0) m_mode = 1;
         else if (m_mode == 2) m_mode = 1;
         else if (m_mode == 3) begin m_mode = 0; m_alarm = 0; m_acnt = 0; end
      end else if (TICK) begin
         if (m_mode == 1) begin
            if (m_secs == 1) begin
               m_exp = 1; m_alarm = 1; m_acnt = 0;
               if (reload_on && m_shadow != 0) m_secs = m_shadow;
               else begin m_secs = 0; m_mode = 3; end
            end else begin
               m_secs = m_secs - 1;
               if (m_alarm) begin
                  m_acnt++;
                  if (m_acnt == ALARM_TICKS) m_alarm = 0;
               end
            end
         end else if (m_mode == 3) begin
            m_acnt++;
            if (m_acnt == ALARM_TICKS) begin m_alarm = 0; m_mode = 0; end
         end
      end
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   always @(negedge CP) begin
      if (cmp_en && nCLR === 1'b1) begin
         chk("model_count", {M1, M0, S1, S0}, to_bcd(m_secs));
         chk("model_running", 16'(RUNNING), 16'(m_mode == 1));
         chk("model_expired", 16'(EXPIRED), 16'(m_exp));
         chk("model_alarm", 16'(ALARM), 16'(m_alarm));
      end
   end

   task automatic cyc(input logic ld, input logic [15:0] v, input logic st,
                      input logic pa, input logic tk);
      LOAD = ld; {LD_M1, LD_M0, LD_S1, LD_S0} = v; START = st; PAUSE = pa; TICK = tk;
      @(posedge CP);
      model_step();
      @(negedge CP);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(0, 16'h0, 0, 0, 1);
   endtask

   initial begin
      nCLR = 1'b0; TICK = 0; LOAD = 0; START = 0; PAUSE = 0;
      {LD_M1, LD_M0, LD_S1, LD_S0} = 16'h0;
      model_reset();
      repeat (2) @(negedge CP);
      chk("reset_count", {M1, M0, S1, S0}, 16'h0000);
      chk("reset_flags", {13'd0, RUNNING, EXPIRED, ALARM}, 16'h0000);
      nCLR = 1'b1;
      cmp_en = 1'b1;

      // borrow chain
      cyc(1, 16'h1000, 0, 0, 0);
      chk("load_1000", {M1, M0, S1, S0}, 16'h1000);
      cyc(0, 16'h0, 1, 0, 0);
      chk("start_running", 16'(RUNNING), 16'h1);
      ticks(1);
      chk("borrow_0959", {M1, M0, S1, S0}, 16'h0959);
      ticks(1);
      chk("borrow_0958", {M1, M0, S1, S0}, 16'h0958);

      // clamping
      cyc(1, 16'h7C83, 0, 0, 0);
      chk("clamp_5953", {M1, M0, S1, S0}, 16'h5953);
      chk("clamp_idle", 16'(RUNNING), 16'h0);

      // expiry and alarm window
      cyc(1, 16'h0002, 0, 0, 0);
      cyc(0, 16'h0, 1, 0, 0);
      ticks(1);
      chk("exp_0001", {M1, M0, S1, S0}, 16'h0001);
      chk("exp_no_early_pulse", 16'(EXPIRED), 16'h0);
      ticks(1);
      chk("exp_count", {M1, M0, S1, S0}, 16'h0000);
      chk("exp_pulse", {13'd0, RUNNING, EXPIRED, ALARM}, 16'h0003);
      cyc(0, 16'h0, 0, 0, 0);
      chk("exp_pulse_end", {13'd0, RUNNING, EXPIRED, ALARM}, 16'h0001);
      ticks(ALARM_TICKS - 1);
      chk("alarm_held", 16'(ALARM), 16'h1);
      ticks(1);
      chk("alarm_off", 16'(ALARM), 16'h0);
      cyc(0, 16'h0, 1, 0, 0);
      chk("zero_start_idle", 16'(RUNNING), 16'h0);

      // pause and precedence
      cyc(1, 16'h0030, 0, 0, 0);
      cyc(0, 16'h0, 1, 0, 0);
      cyc(0, 16'h0, 0, 1, 0);
      chk("paused", 16'(RUNNING), 16'h0);
      ticks(3);
      chk("pause_frozen", {M1, M0, S1, S0}, 16'h0030);
      cyc(0, 16'h0, 1, 1, 0);
      chk("pause_wins", 16'(RUNNING), 16'h0);
      cyc(0, 16'h0, 1, 0, 0);
      chk("resume", 16'(RUNNING), 16'h1);
      ticks(1);
      chk("resume_dec", {M1, M0, S1, S0}, 16'h0029);
      cyc(1, 16'h0045, 0, 0, 1);
      chk("load_over_tick", {M1, M0, S1, S0}, 16'h0045);
      chk("load_idle", 16'(RUNNING), 16'h0);

      // expiry from 00:03, optionally reloading
      cyc(1, 16'h0003, 0, 0, 0);
      cyc(0, 16'h0, 1, 0, 0);
      ticks(3);
`ifdef TIMER_AUTO_RELOAD_EN
      chk("reload_count", {M1, M0, S1, S0}, 16'h0003);
      chk("reload_flags", {13'd0, RUNNING, EXPIRED, ALARM}, 16'h0007);
      ticks(2);
      chk("reload_runs_on", {M1, M0, S1, S0}, 16'h0001);
`else
      chk("done_count", {M1, M0, S1, S0}, 16'h0000);
      chk("done_flags", {13'd0, RUNNING, EXPIRED, ALARM}, 16'h0003);
      cyc(0, 16'h0, 1, 0, 0);
      chk("done_start_clears", {13'd0, RUNNING, EXPIRED, ALARM}, 16'h0000);
`endif

      // asynchronous reset mid-run
      cyc(1, 16'h1234, 0, 0, 0);
      cyc(0, 16'h0, 1, 0, 0);
      ticks(1);
      chk("pre_reset", {M1, M0, S1, S0}, 16'h1233);
      #2 nCLR = 1'b0;
      #1;
      chk("async_count", {M1, M0, S1, S0}, 16'h0000);
      chk("async_flags", {13'd0, RUNNING, EXPIRED, ALARM}, 16'h0000);
      model_reset();
      @(negedge CP);
      nCLR = 1'b1;
      cyc(0, 16'h0, 0, 0, 1);
      chk("post_reset", {M1, M0, S1, S0}, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
